// File: rtl/frame_buffer_dbl.sv
// Double-buffered packed-pixel frame store: one page is scanned out while the other is written,
// and the two pages are exchanged only at frame start.
module frame_buffer_dbl #(
  parameter int unsigned H_RES = 800,
  parameter int unsigned V_RES = 480,
  parameter int unsigned BPP   = 1,
  localparam int unsigned PPW  = (BPP >= 1 && BPP <= 16) ? 16 / BPP : 1,
  localparam int unsigned WPL  = H_RES / PPW,
  localparam int unsigned WPP  = WPL * V_RES,
  localparam int unsigned AW   = $clog2(WPP)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [AW-1:0]  wr_addr,
  input  logic [15:0]    wr_data,
  input  logic           wr_en,
  input  logic           swap_req,
  input  logic [10:0]    vga_h,
  input  logic [10:0]    vga_v,
  output logic [BPP-1:0] pixel_out,
  output logic           pixel_valid,
  output logic           swap_pending,
  output logic           swap_done,
  output logic           front_page
);

  localparam int unsigned PSH   = $clog2(PPW);
  localparam int unsigned SW    = (PSH > 0) ? PSH : 1;
  localparam int unsigned DEPTH = 2 * WPP;
  localparam int unsigned PAW   = $clog2(DEPTH);

  if (!(BPP == 1 || BPP == 2 || BPP == 4 || BPP == 8)) begin : g_bad_bpp
    $error("frame_buffer_dbl: BPP must be 1, 2, 4 or 8");
  end
  if ((H_RES % PPW) != 0) begin : g_bad_hres
    $error("frame_buffer_dbl: H_RES must be a multiple of pixels per word");
  end

  typedef enum logic {ST_IDLE, ST_PENDING} state_e;

  state_e           state_q, state_d;
  logic             front_page_q, front_page_d;
  logic             swap_pending_q, swap_pending_d;
  logic             swap_done_q, swap_done_d;
  logic             frame_start_c;
  logic             flip_c;

  logic             rd_in_range_c;
  logic [PAW-1:0]   rd_addr_c;
  logic             s1_valid_q, s1_valid_d;
  logic [SW-1:0]    s1_slot_q, s1_slot_d;
  logic [BPP-1:0]   pixel_out_q, pixel_out_d;
  logic             pixel_valid_q, pixel_valid_d;

  logic             wr_ok_c;
  logic [PAW-1:0]   wr_phys_c;

  logic [15:0]      mem [DEPTH];
  logic [15:0]      ram_rd_data;

  assign frame_start_c = (vga_h == 11'd0) && (vga_v == 11'd0);

  // Flip sequencer; a request coinciding with frame start from IDLE flips at once.
  always_comb begin
    state_d = state_q;
    flip_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (swap_req) begin
          if (frame_start_c) flip_c = 1'b1;
          else               state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_start_c) begin
          flip_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    front_page_d   = front_page_q ^ flip_c;
    swap_done_d    = flip_c;
    swap_pending_d = (state_d == ST_PENDING);
  end

  // Reads use the post-flip page so a new frame never mixes pages.
  always_comb begin
    rd_in_range_c = (32'(vga_h) < H_RES) && (32'(vga_v) < V_RES);
    rd_addr_c     = PAW'(32'(vga_v) * WPL + (32'(vga_h) >> PSH)
                         + (front_page_d ? WPP : 32'd0));
    s1_valid_d    = rd_in_range_c;
    s1_slot_d     = SW'(vga_h);
    pixel_valid_d = s1_valid_q;
    pixel_out_d   = s1_valid_q ? BPP'(ram_rd_data >> (32'(s1_slot_q) * BPP)) : '0;
  end

  // Writes land in the pre-flip back page; out-of-page addresses are dropped.
  always_comb begin
    wr_ok_c   = wr_en && !reset && (32'(wr_addr) < WPP);
    wr_phys_c = PAW'(32'(wr_addr) + (front_page_q ? 32'd0 : WPP));
  end

  // Simple dual-port RAM, read-first, contents untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_ok_c)       mem[wr_phys_c] <= wr_data;
    if (rd_in_range_c) ram_rd_data    <= mem[rd_addr_c];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      front_page_q   <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_slot_q      <= '0;
      pixel_out_q    <= '0;
      pixel_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      front_page_q   <= front_page_d;
      swap_pending_q <= swap_pending_d;
      swap_done_q    <= swap_done_d;
      s1_valid_q     <= s1_valid_d;
      s1_slot_q      <= s1_slot_d;
      pixel_out_q    <= pixel_out_d;
      pixel_valid_q  <= pixel_valid_d;
    end
  end

  assign pixel_out    = pixel_out_q;
  assign pixel_valid  = pixel_valid_q;
  assign swap_pending = swap_pending_q;
  assign swap_done    = swap_done_q;
  assign front_page   = front_page_q;

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Directed bench for frame_buffer_dbl: a BPP=1 and a BPP=4 instance, pixel results
// checked through a two-cycle scoreboard queue, flip controls checked directly.
module tb_frame_buffer_dbl;

  localparam int unsigned AW     = 15;
  localparam logic [10:0] IDLE_C = 11'd1000;

  logic          clk;
  logic          reset;
  logic [AW-1:0] wr_addr, wr_addr4;
  logic [15:0]   wr_data, wr_data4;
  logic          wr_en, wr_en4, swap_req, swap_req4;
  logic [10:0]   vga_h, vga_v, vga_h4, vga_v4;
  logic          pixel_out;
  logic [3:0]    pixel_out4;
  logic          pixel_valid, pixel_valid4;
  logic          swap_pending, swap_pending4;
  logic          swap_done, swap_done4;
  logic          front_page, front_page4;

  typedef struct packed {
    logic       v1;
    logic       p1;
    logic       v4;
    logic [3:0] p4;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_assert = 0;
  int   n_fail   = 0;

  frame_buffer_dbl u_dut (
    .clk(clk), .reset(reset), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .swap_req(swap_req), .vga_h(vga_h), .vga_v(vga_v), .pixel_out(pixel_out),
    .pixel_valid(pixel_valid), .swap_pending(swap_pending), .swap_done(swap_done),
    .front_page(front_page)
  );

  frame_buffer_dbl #(.H_RES(200), .V_RES(480), .BPP(4)) u_dut4 (
    .clk(clk), .reset(reset), .wr_addr(wr_addr4), .wr_data(wr_data4), .wr_en(wr_en4),
    .swap_req(swap_req4), .vga_h(vga_h4), .vga_v(vga_v4), .pixel_out(pixel_out4),
    .pixel_valid(pixel_valid4), .swap_pending(swap_pending4), .swap_done(swap_done4),
    .front_page(front_page4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_en4 = 1'b0; swap_req = 1'b0; swap_req4 = 1'b0;
    wr_addr = '0; wr_addr4 = '0; wr_data = '0; wr_data4 = '0;
    vga_h = IDLE_C; vga_v = IDLE_C; vga_h4 = IDLE_C; vga_v4 = IDLE_C;
    cur = '0;
  endtask

  // One clock: queue this cycle's expectation, then check the one issued two edges ago.
  task automatic step();
    exp_t f;
    sb_q.push_back(cur);
    @(posedge clk);
    #1;
    if (sb_q.size() >= 2) begin
      f = sb_q.pop_front();
      chk("pix_valid",  16'(pixel_valid),  16'(f.v1));
      chk("pix_out",    16'(pixel_out),    16'(f.p1));
      chk("pix_valid4", 16'(pixel_valid4), 16'(f.v4));
      chk("pix_out4",   16'(pixel_out4),   16'(f.p4));
    end
    idle_inputs();
  endtask

  // Flushed stage 1 means the first post-reset output is a blank pixel.
  task automatic do_reset(input int n);
    idle_inputs();
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    sb_q.push_back('0);
  endtask

  task automatic coord(input logic [10:0] h, input logic [10:0] v, input logic ev, input logic ep);
    vga_h = h; vga_v = v; cur.v1 = ev; cur.p1 = ep;
  endtask

  task automatic coord4(input logic [10:0] h, input logic [10:0] v, input logic [3:0] ep);
    vga_h4 = h; vga_v4 = v; cur.v4 = 1'b1; cur.p4 = ep;
  endtask

  initial begin
    idle_inputs();
    do_reset(2);
    chk("rst_front",   16'(front_page),   16'd0);
    chk("rst_pending", 16'(swap_pending), 16'd0);
    chk("rst_done",    16'(swap_done),    16'd0);
    chk("rst_valid",   16'(pixel_valid),  16'd0);
    chk("rst_pix",     16'(pixel_out),    16'd0);

    // Basic flip: word 0 of page 1 = 0001
    wr_en = 1'b1; wr_addr = '0; wr_data = 16'h0001; step();
    swap_req = 1'b1; step();
    chk("s1_pending", 16'(swap_pending), 16'd1);
    coord(11'd0, 11'd0, 1'b1, 1'b1); step();
    chk("s1_done",     16'(swap_done),    16'd1);
    chk("s1_front",    16'(front_page),   16'd1);
    chk("s1_pend_clr", 16'(swap_pending), 16'd0);
    coord(11'd1, 11'd0, 1'b1, 1'b0); step();
    chk("s1_done_pulse", 16'(swap_done), 16'd0);
    step(); step();

    // BPP=4 slot ordering
    wr_en4 = 1'b1; wr_addr4 = AW'(0); wr_data4 = 16'h0007; step();
    wr_en4 = 1'b1; wr_addr4 = AW'(50); wr_data4 = 16'hA5C3; swap_req4 = 1'b1; step();
    chk("b4_pending", 16'(swap_pending4), 16'd1);
    coord4(11'd0, 11'd0, 4'h7); step();
    chk("b4_done",  16'(swap_done4),  16'd1);
    chk("b4_front", 16'(front_page4), 16'd1);
    coord4(11'd0, 11'd1, 4'h3); step();
    coord4(11'd1, 11'd1, 4'hC); step();
    coord4(11'd2, 11'd1, 4'h5); step();
    coord4(11'd3, 11'd1, 4'hA); step();
    step(); step();

    // Out-of-range coordinates and an out-of-page write (front = 1, back = 0)
    coord(11'd800, 11'd0, 1'b0, 1'b0); step();
    coord(11'd0, 11'd480, 1'b0, 1'b0); step();
    wr_en = 1'b1; wr_addr = '0; wr_data = 16'h0002; step();
    wr_en = 1'b1; wr_addr = AW'(24000); wr_data = 16'hFFFF; step();
    swap_req = 1'b1; step();
    coord(11'd0, 11'd0, 1'b1, 1'b0); step();
    chk("s3_front", 16'(front_page), 16'd0);
    coord(11'd1, 11'd0, 1'b1, 1'b1); step();
    step(); step();

    // Repeated requests collapse into one flip; page 1 word 0 must still be 0001
    swap_req = 1'b1; step();
    step();
    swap_req = 1'b1; step();
    swap_req = 1'b1; step();
    chk("s4_pending", 16'(swap_pending), 16'd1);
    chk("s4_no_done", 16'(swap_done),    16'd0);
    coord(11'd0, 11'd0, 1'b1, 1'b1); step();
    chk("s4_done",  16'(swap_done),  16'd1);
    chk("s4_front", 16'(front_page), 16'd1);
    coord(11'd1, 11'd0, 1'b1, 1'b0); step();
    chk("s4_done_clr", 16'(swap_done),    16'd0);
    chk("s4_pend_clr", 16'(swap_pending), 16'd0);
    coord(11'd0, 11'd0, 1'b1, 1'b1); step();
    chk("s4_no_reflip", 16'(swap_done),  16'd0);
    chk("s4_front_hold", 16'(front_page), 16'd1);
    step(); step();

    // Immediate flip with a same-word write: read returns old 0002, then new 0001
    swap_req = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 16'h0001;
    coord(11'd0, 11'd0, 1'b1, 1'b0); step();
    chk("s5_done",    16'(swap_done),    16'd1);
    chk("s5_front",   16'(front_page),   16'd0);
    chk("s5_pending", 16'(swap_pending), 16'd0);
    coord(11'd1, 11'd0, 1'b1, 1'b0); step();
    coord(11'd0, 11'd0, 1'b1, 1'b1); step();
    chk("s5_no_reflip", 16'(swap_done), 16'd0);
    step(); step();

    // Bring page 1 to the front, then cancel a pending flip with reset
    swap_req = 1'b1; coord(11'd0, 11'd0, 1'b1, 1'b1); step();
    chk("s6_front_pre", 16'(front_page), 16'd1);
    step(); step();
    swap_req = 1'b1; coord(11'd2, 11'd0, 1'b1, 1'b0); step();
    chk("s6_pending", 16'(swap_pending), 16'd1);
    do_reset(1);
    chk("s6_rst_front",   16'(front_page),   16'd0);
    chk("s6_rst_pending", 16'(swap_pending), 16'd0);
    chk("s6_rst_valid",   16'(pixel_valid),  16'd0);
    coord(11'd0, 11'd0, 1'b1, 1'b1); step();
    chk("s6_no_done",  16'(swap_done),    16'd0);
    chk("s6_front",    16'(front_page),   16'd0);
    chk("s6_pend_off", 16'(swap_pending), 16'd0);
    coord(11'd1, 11'd0, 1'b1, 1'b0); step();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_buffer_dbl.md
FRAME_BUFFER_DBL -- requirements
Module: frame_buffer_dbl

Interface
REQ-001 Parameter H_RES, default 800, active pixels per line.
REQ-002 Parameter V_RES, default 480, active lines per frame.
REQ-003 Parameter BPP, default 1, bits per pixel; legal values are 1, 2, 4 and 8.
REQ-004 Derived constants SHALL be PPW = 16/BPP pixels per word, WPL = H_RES/PPW words per line, WPP = WPL*V_RES words per page, and AW = clog2(WPP).
REQ-005 Elaboration SHALL fail if BPP is illegal or H_RES is not a multiple of PPW.
REQ-006 Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_addr  in  AW  page-relative word address for writes.
- wr_data  in  16  packed pixel word to write.
- wr_en  in  1  write strobe; one word is written per cycle.
- swap_req  in  1  request a page flip.
- vga_h  in  11  horizontal pixel coordinate being requested.
- vga_v  in  11  vertical pixel coordinate being requested.
- pixel_out  out  BPP  pixel value.
- pixel_valid  out  1  coordinate was inside the active area, delayed to align with pixel_out.
- swap_pending  out  1  a flip request is waiting for frame start.
- swap_done  out  1  one-cycle pulse on the cycle the flip takes effect.
- front_page  out  1  index of the page currently displayed.

Function
REQ-007 Storage SHALL be two pages of WPP 16-bit words each (2*WPP words), held in one inferred simple dual-port RAM with synchronous read.
REQ-008 Physical word address SHALL be page*WPP + relative address.
REQ-009 Pixel packing: pixel index k within a word (k = 0..PPW-1) SHALL occupy bits [k*BPP +: BPP]; pixel 0 is leftmost on screen.
REQ-010 Read mapping SHALL be word = vga_v*WPL + vga_h/PPW and slot k = vga_h mod PPW, read from page front_page.
REQ-011 Read pipeline SHALL have a fixed latency of 2 clocks:
- stage 1 registers the address, slot and in-range flag;
- stage 2 presents RAM data and selects the slot.
- pixel_out and pixel_valid for the coordinate presented at cycle N appear at cycle N+2.
REQ-012 A coordinate with vga_h >= H_RES or vga_v >= V_RES SHALL produce pixel_out = 0 and pixel_valid = 0 two cycles later, and SHALL not issue a meaningful RAM read.
REQ-013 Writes with wr_en = 1 SHALL target the back page (~front_page) as registered at that cycle; the word is stored at the clock edge.
REQ-014 A write with wr_addr >= WPP SHALL be ignored and SHALL not alias into the other page.
REQ-015 Frame start is the cycle in which vga_h == 0 and vga_v == 0 at the inputs.
REQ-016 Flip state machine, with states IDLE and PENDING:
- IDLE --swap_req--> PENDING.
- PENDING --frame start--> IDLE; front_page toggles and swap_done = 1 for that cycle.
REQ-017 swap_req in the same cycle as frame start, while in IDLE, SHALL flip immediately at that frame start.
REQ-018 swap_req while in PENDING SHALL be absorbed; multiple requests yield one flip.
REQ-019 swap_req is level- or pulse-tolerant; a request held high causes one flip per frame start.
REQ-020 swap_pending SHALL be 1 exactly in state PENDING; in the immediate-flip case of REQ-017 it stays 0.
REQ-021 The read issued in the frame-start cycle SHALL use the post-flip front_page, so the whole new frame comes from one page.
REQ-022 A write in the flip cycle SHALL use the pre-flip back page, which is the new front page.
REQ-023 Read-during-write to the same physical word SHALL return the old data.
REQ-024 Pixels already inside the pipeline at the flip keep the page they were issued with.

Reset
REQ-025 While reset = 1 at a clock edge, the block SHALL set front_page = 0, state = IDLE, swap_pending = 0, swap_done = 0, pixel_out = 0 and pixel_valid = 0, and SHALL flush both pipeline stages.
REQ-026 A write presented in a reset cycle SHALL be dropped.
REQ-027 RAM contents are not cleared by reset and SHALL be retained across reset.
REQ-028 Reset asserted while in PENDING SHALL cancel the request, with no flip and no swap_done.
REQ-029 The first valid pixel after reset deasserts SHALL appear 2 cycles after the first coordinate is presented.

Verification
REQ-030 The bench SHALL cover at least the following directed scenarios (defaults, BPP=1, unless stated):
- Reset, write wr_addr=0 wr_data=16'h0001 (back page 1), swap_req, then present (0,0) -> swap_done at frame start, front_page=1; two cycles later pixel_out=1 and pixel_valid=1; coordinate (1,0) gives pixel_out=0.
- BPP=4, write word 50 (v=1, h=0..3) = 16'hA5C3 on the back page and flip -> (0,1), (1,1), (2,1), (3,1) return 3, C, 5, A on consecutive cycles N+2..N+5.
- Present (800,0) and (0,480) -> pixel_out=0 and pixel_valid=0 two cycles later; write wr_addr=24000 -> front-page word 0 unchanged after the next flip.
- Three swap_req pulses mid-frame -> swap_pending=1; one swap_done at the next (0,0); front_page toggles once.
- swap_req asserted in the frame-start cycle from IDLE -> flip in the same cycle, swap_pending stays 0.
- Set PENDING, assert reset for 1 cycle, then present (0,0) -> no swap_done, front_page=0, and RAM data written before reset is read back intact.
